// File: rtl/dab_mod_pkg.sv
// -----------------------------------------------------------------------------
// dab_mod_pkg
// Shared types, constants and helpers for the DAB triple-phase-shift modulator.
// Angles are 9-bit, 512 LSB = 2*pi, and all phase arithmetic wraps mod 512.
// -----------------------------------------------------------------------------
package dab_mod_pkg;

   localparam int PHASE_W     = 9;
   localparam int HALF_PERIOD = 256;
   localparam int FULL_PERIOD = 512;

   typedef logic [PHASE_W-1:0] phase_t;

   localparam phase_t PHASE_ZERO = phase_t'(0);
   localparam phase_t PHASE_ONE  = phase_t'(1);
   localparam phase_t PHASE_MAX  = phase_t'(FULL_PERIOD - 1);

   // One complete modulation set; tau values are already clamped to 0..255.
   typedef struct packed {
      phase_t tau1;
      phase_t tau2;
      phase_t phi;
   } mod_set_t;

   // Pulse widths are meaningful only as non-negative angles.
   function automatic phase_t clamp_tau(input logic signed [PHASE_W-1:0] v);
      phase_t r;
      if (v[PHASE_W-1]) begin
         r = PHASE_ZERO;
      end else begin
         r = phase_t'(v);
      end
      return r;
   endfunction

   // A leg is high for the first half of its own (shifted) period.
   function automatic logic in_first_half(input phase_t p);
      return (p < phase_t'(HALF_PERIOD));
   endfunction

endpackage

// File: rtl/dab_pwm_modulator_dead_time.sv
// -----------------------------------------------------------------------------
// dead_time_leg
// Complementary hi/lo gate pair for one bridge leg with turn-on delay.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : 0 forces both gates off and presets the dead-time count
//   leg        : desired leg level (1 = hi switch on)
//   hi, lo     : registered gate drives, never both 1
// On a leg edge the conducting switch opens on the next clock and the opposite
// switch closes DT clocks later; an edge during the dead time restarts the count.
// -----------------------------------------------------------------------------
module dead_time_leg #(
   parameter int DT = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic leg,
   output logic hi,
   output logic lo
);

   localparam int CNT_W = (DT < 1) ? 1 : $clog2(DT + 1);
   localparam logic [CNT_W-1:0] CNT_PRESET = CNT_W'(DT);
   localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             leg_prev_q, leg_prev_d;
   logic             hi_q, hi_d;
   logic             lo_q, lo_d;

   // Dead-time count and gate next state.
   always_comb begin
      leg_prev_d = leg;
      cnt_d      = cnt_q;
      hi_d       = 1'b0;
      lo_d       = 1'b0;
      if (!en) begin
         cnt_d = CNT_PRESET;
         hi_d  = 1'b0;
         lo_d  = 1'b0;
      end else begin
         if (leg != leg_prev_q) begin
            cnt_d = CNT_PRESET;
         end else if (cnt_q != CNT_ZERO) begin
            cnt_d = cnt_q - CNT_ONE;
         end else begin
            cnt_d = cnt_q;
         end
         // Gates close only once the count has fully expired.
         hi_d = (cnt_d == CNT_ZERO) &  leg;
         lo_d = (cnt_d == CNT_ZERO) & ~leg;
      end
   end

   // Gate and dead-time state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q      <= CNT_PRESET;
         leg_prev_q <= 1'b0;
         hi_q       <= 1'b0;
         lo_q       <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         leg_prev_q <= leg_prev_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
      end
   end

   assign hi = hi_q;
   assign lo = lo_q;

endmodule

// File: rtl/dab_pwm_modulator.sv
// -----------------------------------------------------------------------------
// dab_pwm_modulator
// Triple-phase-shift gate generator for the DAB primary and secondary bridges.
//   clk, rst_n        : clock, asynchronous active-low reset
//   en                : modulator enable (0 = all gates off, timebase held at 0)
//   div               : phase advances every div+1 clocks
//   tau1, tau2, phi   : signed 9-bit angles, valid when upd is high
//   upd               : 1-clk strobe loading the pending set
//   trigger           : 1-clk pulse at each period start / after en rises
//   applied           : 1-clk pulse when the pending set becomes active
//   upd_overrun       : sticky, a pending set was overwritten before use
//   g_{pa,pb,sc,sd}_{hi,lo} : gate drives for legs A, B, C, D
// New values are only ever switched in at the period wrap so each period is
// generated from one consistent set.
// -----------------------------------------------------------------------------
module dab_pwm_modulator
   import dab_mod_pkg::*;
#(
   parameter int DT    = 4,
   parameter int DIV_W = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      en,
   input  logic [DIV_W-1:0]          div,
   input  logic signed [PHASE_W-1:0] tau1,
   input  logic signed [PHASE_W-1:0] tau2,
   input  logic signed [PHASE_W-1:0] phi,
   input  logic                      upd,
   output logic                      trigger,
   output logic                      applied,
   output logic                      upd_overrun,
   output logic                      g_pa_hi,
   output logic                      g_pa_lo,
   output logic                      g_pb_hi,
   output logic                      g_pb_lo,
   output logic                      g_sc_hi,
   output logic                      g_sc_lo,
   output logic                      g_sd_hi,
   output logic                      g_sd_lo
);

   localparam logic [DIV_W-1:0] DIV_ZERO = {DIV_W{1'b0}};
   localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

   logic [DIV_W-1:0] presc_q, presc_d;
   phase_t           phase_q, phase_d;
   logic             en_q, en_d;
   logic             trigger_q, trigger_d;
   logic             applied_q, applied_d;
   logic             overrun_q, overrun_d;
   logic             pend_vld_q, pend_vld_d;
   mod_set_t         act_q, act_d;
   mod_set_t         pend_q, pend_d;
   logic [3:0]       leg_q, leg_d;

   logic             tick_s;
   logic             wrap_s;
   phase_t           diff_b_s, diff_c_s, diff_d_s;
   logic [3:0]       gate_hi_s, gate_lo_s;

   // Timebase events; >= keeps a shrinking div from running the prescaler away.
   always_comb begin
      tick_s = en & (presc_q >= div);
      wrap_s = tick_s & (phase_q == PHASE_MAX);
   end

   // Prescaler and phase counter next state.
   always_comb begin
      presc_d = presc_q;
      phase_d = phase_q;
      if (!en) begin
         presc_d = DIV_ZERO;
         phase_d = PHASE_ZERO;
      end else if (tick_s) begin
         presc_d = DIV_ZERO;
         phase_d = phase_q + PHASE_ONE;
      end else begin
         presc_d = presc_q + DIV_ONE;
         phase_d = phase_q;
      end
   end

   // Pending/active handshake; an upd on the wrap cycle queues behind the applied set.
   always_comb begin
      pend_d     = pend_q;
      pend_vld_d = pend_vld_q;
      act_d      = act_q;
      applied_d  = 1'b0;
      overrun_d  = overrun_q;
      if (wrap_s && pend_vld_q) begin
         act_d      = pend_q;
         applied_d  = 1'b1;
         pend_vld_d = 1'b0;
      end else begin
         act_d      = act_q;
         applied_d  = 1'b0;
      end
      if (upd) begin
         pend_d.tau1 = clamp_tau(tau1);
         pend_d.tau2 = clamp_tau(tau2);
         pend_d.phi  = phase_t'(phi);
         pend_vld_d  = 1'b1;
         if (pend_vld_q && !wrap_s) begin
            overrun_d = 1'b1;
         end else begin
            overrun_d = overrun_q;
         end
      end else begin
         pend_d = pend_q;
      end
   end

   // Period trigger: wrap to phase 0, or first cycle after enable.
   always_comb begin
      en_d      = en;
      trigger_d = wrap_s | (en & ~en_q);
   end

   // Raw leg levels from the active set (all differences wrap mod 512).
   always_comb begin
      diff_b_s = phase_q - act_q.tau1;
      diff_c_s = phase_q - act_q.phi;
      diff_d_s = diff_c_s - act_q.tau2;
      leg_d    = {in_first_half(diff_d_s), in_first_half(diff_c_s),
                  in_first_half(diff_b_s), in_first_half(phase_q)};
   end

   // Timebase, handshake and leg registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_q    <= DIV_ZERO;
         phase_q    <= PHASE_ZERO;
         en_q       <= 1'b0;
         trigger_q  <= 1'b0;
         applied_q  <= 1'b0;
         overrun_q  <= 1'b0;
         pend_vld_q <= 1'b0;
         act_q      <= {PHASE_ZERO, PHASE_ZERO, PHASE_ZERO};
         pend_q     <= {PHASE_ZERO, PHASE_ZERO, PHASE_ZERO};
         leg_q      <= 4'b0000;
      end else begin
         presc_q    <= presc_d;
         phase_q    <= phase_d;
         en_q       <= en_d;
         trigger_q  <= trigger_d;
         applied_q  <= applied_d;
         overrun_q  <= overrun_d;
         pend_vld_q <= pend_vld_d;
         act_q      <= act_d;
         pend_q     <= pend_d;
         leg_q      <= leg_d;
      end
   end

   // Legs 0..3 are A, B, C, D.
   for (genvar i = 0; i < 4; i++) begin : g_leg
      dead_time_leg #(
         .DT (DT)
      ) u_dead_time (
         .clk   (clk),
         .rst_n (rst_n),
         .en    (en),
         .leg   (leg_q[i]),
         .hi    (gate_hi_s[i]),
         .lo    (gate_lo_s[i])
      );
   end

   assign trigger     = trigger_q;
   assign applied     = applied_q;
   assign upd_overrun = overrun_q;
   assign g_pa_hi     = gate_hi_s[0];
   assign g_pa_lo     = gate_lo_s[0];
   assign g_pb_hi     = gate_hi_s[1];
   assign g_pb_lo     = gate_lo_s[1];
   assign g_sc_hi     = gate_hi_s[2];
   assign g_sc_lo     = gate_lo_s[2];
   assign g_sd_hi     = gate_hi_s[3];
   assign g_sd_lo     = gate_lo_s[3];

endmodule
